rv32i_writeback: RTL and testbench
==================================

# rv32i_writeback

Writeback stage directly upstream of the RV32I register file. It merges single-cycle ALU results and handshaked load-data returns from the memory interface, sign- or zero-extends the load data, and drives the register file's single write port (`rd_addr`/`rd_data`/`rd_we`) from registered outputs. It holds at most one pending load in a one-entry buffer and keeps a pending-load scoreboard so that hazard logic can stall on registers whose load has not yet been written back.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `alu_valid` input 1: ALU result present this cycle; it always completes and is never back-pressured.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `ld_issue` input 1: a load to `ld_issue_rd` was issued to memory this cycle.
- `ld_issue_rd` input 5: destination register of the issued load.
- `mem_valid` input 1: load data returned.
- `mem_ready` output 1: the stage accepts the load return this cycle.
- `mem_rd` input 5: destination register of the returned load.
- `mem_rdata` input 32: word-aligned read data.
- `mem_funct3` input 3: load type.
- `mem_addr_lo` input 2: byte offset of the load address.
- `rd_addr` output 5, `rd_data` output 32, `rd_we` output 1: register-file write port, all registered.
- `busy` output 32: pending-load scoreboard, one bit per register; bit 0 is always 0.

## Operation
- One-entry load buffer, state EMPTY or FULL, holding `buf_rd` and `buf_data`. `buf_data` is already extended.
- `alu_wr` = `alu_valid` and `alu_rd` != 0.
- Write select each cycle, by priority:
  - If `alu_wr`: write the ALU result.
  - Else if FULL and `buf_rd` != 0: write the buffer (this is a drain).
  - Otherwise no write.
- Supersede: if FULL, `alu_wr`, and `alu_rd` == `buf_rd`, the buffer is discarded. The younger ALU write wins (WAW).
- `mem_ready` = EMPTY, or FULL and (drain or supersede) this cycle.
- Buffer state on each clock edge:
  - Handshake (`mem_valid` and `mem_ready`): buffer goes FULL with the new entry.
  - Else, drain or supersede: buffer goes EMPTY.
  - Otherwise it holds.
- Load returns with `mem_rd` == 0 are accepted and discarded: the buffer stays or becomes EMPTY.
- Extension by `mem_funct3`; the byte is selected by `mem_addr_lo` and the halfword by `mem_addr_lo[1]`:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 010 LW: whole word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the halfword.
  - Any other value: treated as LW.
- Scoreboard:
  - `ld_issue` with `ld_issue_rd` != 0 sets `busy[ld_issue_rd]`.
  - A drain or supersede of `buf_rd` clears the bit.
  - Set and clear of the same bit in the same cycle: set wins.

## Timing
- Reset (asynchronous): `rd_we`=0, `rd_addr`=0, `rd_data`=0, buffer EMPTY, `busy`=0, so `mem_ready`=1.
- Reset mid-operation drops any buffered load and clears the scoreboard immediately.
- ALU path: `alu_valid` in cycle N gives `rd_we`=1 in cycle N+1, and the register file is written at the end of cycle N+1.
- Load path: accepted in cycle N; drains in cycle N+1 at the earliest; `rd_we`=1 in cycle N+2.
- Load back-to-back throughput: one return per cycle while no ALU writes occur.
- Each ALU write without supersede stalls the buffer one cycle, and `mem_ready` is low for that cycle.
- `rd_we` is a single-cycle pulse per write. `rd_addr` and `rd_data` hold their last written values while `rd_we`=0.
- `mem_ready` is combinational from `alu_valid`, `alu_rd`, and buffer state; it has no dependency on `mem_valid`.

## Configuration
- `RV32_WB_SCOREBOARD_EN` defined: scoreboard is implemented as described.
- Not defined:
  - `busy` is constant 0 and `ld_issue`/`ld_issue_rd` are ignored.
  - The ports remain present.
  - The write path, buffer, and supersede behaviour are unchanged.

## Structure
- Shared package `rv32i_pkg`:
  - Load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - Buffer state encoding `WB_EMPTY`/`WB_FULL`.
- Sub-module `rv32i_load_extend`: combinational, taking `mem_rdata`, `mem_funct3`, and `mem_addr_lo` and producing the extended word. The load-store unit reuses it.

## Test plan
- Reset release, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 in cycle N → `rd_we`=1, `rd_addr`=5, `rd_data`=0x1234 in cycle N+1, and `rd_we`=0 in cycle N+2.
- Load `mem_rdata`=0x80FF7F01 with no ALU activity:
  - LB, offset 3 → 0xFFFFFF80.
  - LBU, offset 3 → 0x00000080.
  - LH, offset 2 → 0xFFFF80FF.
  - LHU, offset 0 → 0x00007F01.
  - LW → 0x80FF7F01.
  - Each appears on `rd_data` two cycles after acceptance.
- Buffer FULL (rd 7) with `alu_valid` to rd 3 for 2 cycles, and `mem_valid` held:
  - `mem_ready`=0 both cycles.
  - x3 is written twice, then x7 in the third cycle.
- Supersede: buffer FULL (rd 9, 0xAAAA) and ALU to rd 9 with 0x5555 → only 0x5555 is written; the buffer goes EMPTY; `busy[9]` clears.
- Scoreboard: `ld_issue` rd 4 → `busy[4]`=1 the next cycle; it stays 1 until the drain cycle, then 0. Issuing rd 4 in the same cycle as its drain keeps `busy[4]`=1.
- Assert `rst_n`=0 while FULL with `busy` nonzero → all outputs 0 and `mem_ready`=1 asynchronously; no stale write after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load funct3 codes, writeback buffer state and entry payload.
package rv32i_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned NREGS  = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_EMPTY = 1'b0,
      WB_FULL  = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rv32i_load_extend.sv
// Load data alignment and sign/zero extension from a word-aligned read.
module rv32i_load_extend
   import rv32i_pkg::*;
(
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [2:0]        mem_funct3,
   input  logic [1:0]        mem_addr_lo,
   output logic [DATA_W-1:0] ext_data_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = mem_rdata[7:0];
      case (mem_addr_lo)
         2'd0:    byte_c = mem_rdata[7:0];
         2'd1:    byte_c = mem_rdata[15:8];
         2'd2:    byte_c = mem_rdata[23:16];
         default: byte_c = mem_rdata[31:24];
      endcase
      half_c = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Reserved funct3 values fall back to a full-word load.
   always_comb begin
      ext_data_c = mem_rdata;
      case (mem_funct3)
         F3_LB:   ext_data_c = {{24{byte_c[7]}}, byte_c};
         F3_LH:   ext_data_c = {{16{half_c[15]}}, half_c};
         F3_LBU:  ext_data_c = {24'd0, byte_c};
         F3_LHU:  ext_data_c = {16'd0, half_c};
         default: ext_data_c = mem_rdata;
      endcase
   end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback: merges ALU results and buffered load returns onto the regfile write port.
// Optional pending-load scoreboard enabled by RV32_WB_SCOREBOARD_EN.
module rv32i_writeback
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_issue,
   input  logic [4:0]        ld_issue_rd,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [4:0]        mem_rd,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic [2:0]        mem_funct3,
   input  logic [1:0]        mem_addr_lo,
   output logic [4:0]        rd_addr,
   output logic [XLEN-1:0]   rd_data,
   output logic              rd_we,
   output logic [XLEN-1:0]   busy
);

   wb_state_t         state, state_nxt;
   wb_entry_t         buf_q;
   logic [DATA_W-1:0] ext_c;
   logic              alu_wr_c;
   logic              drain_c;
   logic              supersede_c;
   logic              release_c;
   logic              accept_c;

   rv32i_load_extend u_ext (
      .mem_rdata   (DATA_W'(mem_rdata)),
      .mem_funct3  (mem_funct3),
      .mem_addr_lo (mem_addr_lo),
      .ext_data_c  (ext_c)
   );

   // The buffer never holds x0, so FULL alone qualifies a drain.
   always_comb begin
      alu_wr_c    = alu_valid && (alu_rd != 5'd0);
      drain_c     = (state == WB_FULL) && !alu_wr_c;
      supersede_c = (state == WB_FULL) && alu_wr_c && (alu_rd == buf_q.rd);
      release_c   = drain_c || supersede_c;
      mem_ready   = (state == WB_EMPTY) || release_c;
      accept_c    = mem_valid && mem_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WB_EMPTY;
      else        state <= state_nxt;
   end

   // Returns to x0 are accepted but never occupy the buffer.
   always_comb begin
      state_nxt = state;
      if (accept_c)
         state_nxt = (mem_rd != 5'd0) ? WB_FULL : WB_EMPTY;
      else if (release_c)
         state_nxt = WB_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         rd_we   <= 1'b0;
         rd_addr <= 5'd0;
         rd_data <= '0;
      end else begin
         if (accept_c) begin
            buf_q.rd   <= mem_rd;
            buf_q.data <= ext_c;
         end
         rd_we <= alu_wr_c || drain_c;
         if (alu_wr_c) begin
            rd_addr <= alu_rd;
            rd_data <= alu_data;
         end else if (drain_c) begin
            rd_addr <= buf_q.rd;
            rd_data <= XLEN'(buf_q.data);
         end
      end
   end

`ifdef RV32_WB_SCOREBOARD_EN
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] set_c;
   logic [NREGS-1:0] clr_c;

   // Set takes precedence over a same-cycle clear of the same register.
   always_comb begin
      set_c = '0;
      clr_c = '0;
      if (ld_issue && (ld_issue_rd != 5'd0)) set_c[ld_issue_rd] = 1'b1;
      if (release_c)                         clr_c[buf_q.rd]    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= ((busy_q & ~clr_c) | set_c) & ~NREGS'(1);
   end

   assign busy = XLEN'(busy_q);
`else
   logic unused_issue;
   assign unused_issue = ^{ld_issue, ld_issue_rd};
   assign busy         = '0;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed scenarios plus random traffic vs a reference model.
module tb_rv32i_writeback;

`ifdef RV32_WB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_rdata;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lo;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_we;
   logic [31:0] busy;

   int vectors;
   int miscompares;

   // Reference model: abstract pending load plus the expected regfile write.
   bit          m_full;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [31:0] m_busy;
   bit          e_we;
   logic [4:0]  e_addr;
   logic [31:0] e_data;

   rv32i_writeback #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .mem_funct3  (mem_funct3),
      .mem_addr_lo (mem_addr_lo),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_we       (rd_we),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic bit ref_ready();
      bit alu_wr;
      alu_wr = alu_valid && (alu_rd != 5'd0);
      return !m_full || !alu_wr || (alu_rd == m_rd);
   endfunction

   task automatic model_reset();
      m_full = 0; m_rd = '0; m_data = '0; m_busy = '0;
      e_we = 0; e_addr = '0; e_data = '0;
   endtask

   task automatic model_update();
      bit alu_wr;
      bit ready;
      bit freed;
      alu_wr = alu_valid && (alu_rd != 5'd0);
      ready  = ref_ready();
      freed  = m_full && ready;
      if (alu_wr) begin
         e_we = 1; e_addr = alu_rd; e_data = alu_data;
      end else if (m_full) begin
         e_we = 1; e_addr = m_rd; e_data = m_data;
      end else begin
         e_we = 0;
      end
      if (SB_EN) begin
         if (freed) m_busy[m_rd] = 1'b0;
         if (ld_issue && ld_issue_rd != 5'd0) m_busy[ld_issue_rd] = 1'b1;
      end
      if (mem_valid && ready) begin
         m_full = (mem_rd != 5'd0);
         m_rd   = mem_rd;
         m_data = ref_ext(mem_rdata, mem_funct3, mem_addr_lo);
      end else if (freed) begin
         m_full = 0;
      end
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      ld_issue = 0; ld_issue_rd = '0;
      mem_valid = 0; mem_rd = '0; mem_rdata = '0; mem_funct3 = '0; mem_addr_lo = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #17;
      vectors++;
      if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0 || busy !== 32'd0 || mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: we=%b addr=%0d data=%h busy=%h ready=%b, required all 0, ready 1",
                  rd_we, rd_addr, rd_data, busy, mem_ready);
      end
      @(negedge clk);
      rst_n = 1;
      model_reset();
      tick();
   endtask

   task automatic test_alu();
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
      #1;
      vectors++;
      if (mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL alu_ready: got %b required 1", mem_ready);
      end
      tick();
      idle();
      vectors++;
      if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234) begin
         miscompares++;
         $display("FAIL alu_write: we=%b addr=%0d data=%h, required 1/5/00001234", rd_we, rd_addr, rd_data);
      end
      tick();
      vectors++;
      if (rd_we !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'h1234) begin
         miscompares++;
         $display("FAIL alu_pulse: we=%b addr=%0d data=%h, required 0/5/00001234 held", rd_we, rd_addr, rd_data);
      end
   endtask

   task automatic test_load_extend();
      logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
      for (int i = 0; i < 5; i++) begin
         mem_valid = 1; mem_rd = 5'd10; mem_rdata = 32'h80FF7F01;
         mem_funct3 = f3[i]; mem_addr_lo = off[i];
         tick();
         idle();
         vectors++;
         if (rd_we !== 1'b0) begin
            miscompares++;
            $display("FAIL load_early_%0d: rd_we=%b one cycle after accept, required 0", i, rd_we);
         end
         tick();
         vectors++;
         if (rd_we !== 1'b1 || rd_addr !== 5'd10 || rd_data !== exp[i]) begin
            miscompares++;
            $display("FAIL load_ext_%0d: we=%b addr=%0d data=%h, required 1/10/%h",
                     i, rd_we, rd_addr, rd_data, exp[i]);
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      mem_valid = 1; mem_rd = 5'd7; mem_rdata = 32'h77; mem_funct3 = 3'b010; mem_addr_lo = 2'd0;
      tick();
      mem_rd = 5'd8; mem_rdata = 32'h88;
      for (int i = 0; i < 2; i++) begin
         alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33 + 32'(i);
         #1;
         vectors++;
         if (mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_ready_%0d: got %b required 0", i, mem_ready);
         end
         tick();
         vectors++;
         if (rd_we !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h33 + 32'(i)) begin
            miscompares++;
            $display("FAIL stall_alu_%0d: we=%b addr=%0d data=%h, required 1/3/%h",
                     i, rd_we, rd_addr, rd_data, 32'h33 + 32'(i));
         end
      end
      alu_valid = 0; alu_rd = '0;
      #1;
      vectors++;
      if (mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_ready: got %b required 1", mem_ready);
      end
      tick();
      idle();
      vectors++;
      if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77) begin
         miscompares++;
         $display("FAIL stall_drain: we=%b addr=%0d data=%h, required 1/7/00000077", rd_we, rd_addr, rd_data);
      end
      tick();
      vectors++;
      if (rd_we !== 1'b1 || rd_addr !== 5'd8 || rd_data !== 32'h88) begin
         miscompares++;
         $display("FAIL b2b_next: we=%b addr=%0d data=%h, required 1/8/00000088", rd_we, rd_addr, rd_data);
      end
      tick();
   endtask

   task automatic test_supersede();
      ld_issue = 1; ld_issue_rd = 5'd9;
      tick();
      idle();
      mem_valid = 1; mem_rd = 5'd9; mem_rdata = 32'hAAAA; mem_funct3 = 3'b010;
      tick();
      idle();
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h5555;
      #1;
      vectors++;
      if (mem_ready !== 1'b1 || busy[9] !== SB_EN) begin
         miscompares++;
         $display("FAIL sup_pre: ready=%b busy9=%b, required 1/%b", mem_ready, busy[9], SB_EN);
      end
      tick();
      idle();
      vectors++;
      if (rd_we !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h5555 || busy[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL sup_write: we=%b addr=%0d data=%h busy9=%b, required 1/9/00005555/0",
                  rd_we, rd_addr, rd_data, busy[9]);
      end
      tick();
      vectors++;
      if (rd_we !== 1'b0 || rd_data !== 32'h5555) begin
         miscompares++;
         $display("FAIL sup_discard: we=%b data=%h, required 0/00005555", rd_we, rd_data);
      end
   endtask

   task automatic test_scoreboard();
      ld_issue = 1; ld_issue_rd = 5'd4;
      tick();
      idle();
      vectors++;
      if (busy[4] !== SB_EN) begin
         miscompares++;
         $display("FAIL sb_set: busy4=%b required %b", busy[4], SB_EN);
      end
      mem_valid = 1; mem_rd = 5'd4; mem_rdata = 32'h4444; mem_funct3 = 3'b010;
      tick();
      idle();
      vectors++;
      if (busy[4] !== SB_EN) begin
         miscompares++;
         $display("FAIL sb_hold: busy4=%b required %b", busy[4], SB_EN);
      end
      tick();
      vectors++;
      if (busy[4] !== 1'b0 || rd_we !== 1'b1 || rd_addr !== 5'd4) begin
         miscompares++;
         $display("FAIL sb_clear: busy4=%b we=%b addr=%0d, required 0/1/4", busy[4], rd_we, rd_addr);
      end
      mem_valid = 1; mem_rd = 5'd4; mem_rdata = 32'h4545; mem_funct3 = 3'b010;
      tick();
      idle();
      ld_issue = 1; ld_issue_rd = 5'd4;
      tick();
      idle();
      vectors++;
      if (busy[4] !== SB_EN || rd_data !== 32'h4545) begin
         miscompares++;
         $display("FAIL sb_set_wins: busy4=%b data=%h, required %b/00004545", busy[4], rd_data, SB_EN);
      end
   endtask

   task automatic test_reset_mid();
      ld_issue = 1; ld_issue_rd = 5'd12;
      mem_valid = 1; mem_rd = 5'd12; mem_rdata = 32'hC0C0; mem_funct3 = 3'b010;
      tick();
      idle();
      alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h22;
      tick();
      idle();
      #1;
      rst_n = 0;
      #1;
      model_reset();
      vectors++;
      if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0 || busy !== 32'd0 || mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: we=%b addr=%0d data=%h busy=%h ready=%b, required all 0, ready 1",
                  rd_we, rd_addr, rd_data, busy, mem_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();
      vectors++;
      if (rd_we !== 1'b0 || rd_addr !== 5'd0 || busy !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_stale: we=%b addr=%0d busy=%h, required 0/0/0", rd_we, rd_addr, busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         alu_valid   = ($urandom_range(0, 2) == 0);
         alu_rd      = 5'($urandom_range(0, 7));
         alu_data    = $urandom;
         ld_issue    = ($urandom_range(0, 2) == 0);
         ld_issue_rd = 5'($urandom_range(0, 7));
         mem_valid   = ($urandom_range(0, 1) == 0);
         mem_rd      = 5'($urandom_range(0, 7));
         mem_rdata   = $urandom;
         mem_funct3  = 3'($urandom_range(0, 7));
         mem_addr_lo = 2'($urandom_range(0, 3));
         #1;
         vectors++;
         if (mem_ready !== ref_ready()) begin
            miscompares++;
            $display("FAIL rand_ready@%0d: got %b required %b", i, mem_ready, ref_ready());
         end
         tick();
         vectors++;
         if (rd_we !== e_we || (e_we && (rd_addr !== e_addr || rd_data !== e_data)) || busy !== m_busy) begin
            miscompares++;
            $display("FAIL rand_write@%0d: we=%b addr=%0d data=%h busy=%h, required %b/%0d/%h/%h",
                     i, rd_we, rd_addr, rd_data, busy, e_we, e_addr, e_data, m_busy);
         end
      end
      idle();
      tick();
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_reset();
      test_reset();
      test_alu();
      test_load_extend();
      test_back_to_back();
      test_supersede();
      test_scoreboard();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
